// File: rtl/stage_link.sv
// stage_link: DEPTH-entry valid/ready FIFO carrying the write-back bundle between pipeline
// stages, with synchronous flush and a youngest-match register-forwarding lookup.
module stage_link #(
    parameter int  ADDR_WIDTH = 5,
    parameter int  DATA_WIDTH = 32,
    parameter int  DEPTH      = 2,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_regW,
    input  logic [ADDR_WIDTH-1:0] in_regAddr,
    input  logic [DATA_WIDTH-1:0] in_regData,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_regW,
    output logic [ADDR_WIDTH-1:0] out_regAddr,
    output logic [DATA_WIDTH-1:0] out_regData,
    input  logic [ADDR_WIDTH-1:0] fwd_addr,
    output logic                  fwd_hit,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic [CNT_W-1:0]      count
);
    localparam int PTR_W = $clog2(DEPTH);

    // Handshake: a bundle moves on a rising edge where valid and ready are both high.
    // in_ready looks only at registered occupancy, so a full buffer refuses a push even
    // in a cycle where its head is being popped; the freed slot is offered next cycle.
    logic                  push;
    logic                  pop;
    logic [PTR_W-1:0]      rdPtr;
    logic [PTR_W-1:0]      wrPtr;
    logic [PTR_W-1:0]      fwdIdx;
    logic                  memRegW    [DEPTH];
    logic [ADDR_WIDTH-1:0] memRegAddr [DEPTH];
    logic [DATA_WIDTH-1:0] memRegData [DEPTH];

    assign in_ready  = (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_regW    = out_valid ? memRegW[rdPtr]    : 1'b0;
    assign out_regAddr = out_valid ? memRegAddr[rdPtr] : '0;
    assign out_regData = out_valid ? memRegData[rdPtr] : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
            rdPtr <= '0;
            wrPtr <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Payload storage is left unreset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            memRegW[wrPtr]    <= in_regW;
            memRegAddr[wrPtr] <= in_regAddr;
            memRegData[wrPtr] <= in_regData;
        end
    end

    // Walk entries oldest to youngest so the last match wins; address 0 never forwards.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwdIdx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwdIdx = rdPtr + PTR_W'(i);
            if ((CNT_W'(i) < count) && memRegW[fwdIdx] &&
                (memRegAddr[fwdIdx] == fwd_addr) && (fwd_addr != '0)) begin
                fwd_hit  = 1'b1;
                fwd_data = memRegData[fwdIdx];
            end
        end
    end
endmodule

// File: tb/tb_stage_link.sv
// Bench for stage_link: directed vector table for the handshake, forwarding, flush and
// reset corners, then steady streaming and random traffic against a queue model.
module tb_stage_link;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DEPTH = 2;
    localparam int BW = 1 + AW + DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_regW = 1'b0;
    logic [AW-1:0] in_regAddr = '0;
    logic [DW-1:0] in_regData = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_regW;
    logic [AW-1:0] out_regAddr;
    logic [DW-1:0] out_regData;
    logic [AW-1:0] fwd_addr = '0;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [1:0]    count;

    int n_checks = 0;
    int n_fail = 0;
    logic [BW-1:0] exp_q[$];

    stage_link #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_regW(in_regW), .in_regAddr(in_regAddr), .in_regData(in_regData),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_regW(out_regW), .out_regAddr(out_regAddr), .out_regData(out_regData),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .count(count)
    );

    // Clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic          rst, flush, iv, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          ordy;
        logic [AW-1:0] fa;
        logic [1:0]    cnt;
        logic          irdy, ov, ow;
        logic [AW-1:0] oa;
        logic [DW-1:0] od;
        logic          fh;
        logic [DW-1:0] fd;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mkv(int r, int fl, int iv, int w, int a, int d, int ordy, int fa,
                                 int cnt, int irdy, int ov, int ow, int oa, int od,
                                 int fh, int fd);
        vec_t v;
        v.rst = 1'(r);    v.flush = 1'(fl);   v.iv = 1'(iv);  v.w = 1'(w);
        v.a = AW'(a);     v.d = DW'(d);       v.ordy = 1'(ordy); v.fa = AW'(fa);
        v.cnt = 2'(cnt);  v.irdy = 1'(irdy);  v.ov = 1'(ov);  v.ow = 1'(ow);
        v.oa = AW'(oa);   v.od = DW'(od);     v.fh = 1'(fh);  v.fd = DW'(fd);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Driver
    task automatic drive(input logic r, input logic fl, input logic iv, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic ordy, input logic [AW-1:0] fa);
        rst = r; flush = fl; in_valid = iv; in_regW = w;
        in_regAddr = a; in_regData = d; out_ready = ordy; fwd_addr = fa;
    endtask

    task automatic check_outputs(input string tag, input logic [1:0] ecnt, input logic eirdy,
                                 input logic eov, input logic eow, input logic [AW-1:0] eoa,
                                 input logic [DW-1:0] eod, input logic efh,
                                 input logic [DW-1:0] efd);
        chk({tag, ".count"},     32'(count),       32'(ecnt));
        chk({tag, ".in_ready"},  32'(in_ready),    32'(eirdy));
        chk({tag, ".out_valid"}, 32'(out_valid),   32'(eov));
        chk({tag, ".out_regW"},  32'(out_regW),    32'(eow));
        chk({tag, ".out_addr"},  32'(out_regAddr), 32'(eoa));
        chk({tag, ".out_data"},  out_regData,      eod);
        chk({tag, ".fwd_hit"},   32'(fwd_hit),     32'(efh));
        chk({tag, ".fwd_data"},  fwd_data,         efd);
    endtask

    // Scoreboard: the queue holds accepted bundles oldest first as {regW, regAddr, regData}.
    task automatic model_cycle(input string tag, input logic iv, input logic ordy,
                               input logic fl, input logic w, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [AW-1:0] fa);
        int            n;
        logic [BW-1:0] head;
        logic          e_hit;
        logic [DW-1:0] e_fd;
        @(negedge clk);
        drive(1'b0, fl, iv, w, a, d, ordy, fa);
        #1;
        n = exp_q.size();
        head = (n != 0) ? exp_q[0] : '0;
        e_hit = 1'b0;
        e_fd = '0;
        foreach (exp_q[i]) begin
            if (exp_q[i][BW-1] && exp_q[i][DW+AW-1:DW] == fa && fa != '0) begin
                e_hit = 1'b1;
                e_fd = exp_q[i][DW-1:0];
            end
        end
        check_outputs(tag, 2'(n), n < DEPTH, n != 0, head[BW-1], head[DW+AW-1:DW],
                      head[DW-1:0], e_hit, e_fd);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (ordy && n != 0) void'(exp_q.pop_front());
            if (iv && n < DEPTH) exp_q.push_back({w, a, d});
        end
    endtask

    initial begin
        vecs[0]  = mkv(0,0,1,1,5,'h11, 0,0, 0,1,0,0,0,0,     0,0);
        vecs[1]  = mkv(0,0,1,1,6,'h22, 0,5, 1,1,1,1,5,'h11,  1,'h11);
        vecs[2]  = mkv(0,0,1,1,7,'h33, 0,6, 2,0,1,1,5,'h11,  1,'h22);
        vecs[3]  = mkv(0,0,0,0,0,0,    1,5, 2,0,1,1,5,'h11,  1,'h11);
        vecs[4]  = mkv(0,0,0,0,0,0,    1,5, 1,1,1,1,6,'h22,  0,0);
        vecs[5]  = mkv(0,0,0,0,0,0,    0,6, 0,1,0,0,0,0,     0,0);
        vecs[6]  = mkv(0,0,1,1,1,'h101,0,0, 0,1,0,0,0,0,     0,0);
        vecs[7]  = mkv(0,0,1,1,2,'h102,0,0, 1,1,1,1,1,'h101, 0,0);
        vecs[8]  = mkv(0,0,1,1,3,'h103,1,2, 2,0,1,1,1,'h101, 1,'h102);
        vecs[9]  = mkv(0,0,0,0,0,0,    0,3, 1,1,1,1,2,'h102, 0,0);
        vecs[10] = mkv(0,0,0,0,0,0,    1,2, 1,1,1,1,2,'h102, 1,'h102);
        vecs[11] = mkv(0,0,1,1,3,'hA,  0,3, 0,1,0,0,0,0,     0,0);
        vecs[12] = mkv(0,0,1,1,3,'hB,  0,3, 1,1,1,1,3,'hA,   1,'hA);
        vecs[13] = mkv(0,0,0,0,0,0,    0,3, 2,0,1,1,3,'hA,   1,'hB);
        vecs[14] = mkv(0,1,1,1,9,'hEE, 0,3, 2,0,1,1,3,'hA,   1,'hB);
        vecs[15] = mkv(0,0,0,0,0,0,    1,9, 0,1,0,0,0,0,     0,0);
        vecs[16] = mkv(0,0,1,1,0,'h55, 0,0, 0,1,0,0,0,0,     0,0);
        vecs[17] = mkv(0,0,1,0,3,'h66, 0,0, 1,1,1,1,0,'h55,  0,0);
        vecs[18] = mkv(0,0,0,0,0,0,    1,3, 2,0,1,1,0,'h55,  0,0);
        vecs[19] = mkv(0,0,0,0,0,0,    0,3, 1,1,1,0,3,'h66,  0,0);
        vecs[20] = mkv(0,0,1,1,4,'h77, 0,0, 1,1,1,0,3,'h66,  0,0);
        vecs[21] = mkv(1,0,1,1,8,'h88, 1,4, 2,0,1,0,3,'h66,  1,'h77);
        vecs[22] = mkv(0,0,0,0,0,0,    0,4, 0,1,0,0,0,0,     0,0);
        vecs[23] = mkv(0,1,1,1,9,'hEE, 1,9, 0,1,0,0,0,0,     0,0);
        vecs[24] = mkv(0,0,0,0,0,0,    1,9, 0,1,0,0,0,0,     0,0);

        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Directed table: inputs driven at the falling edge, outputs checked before the rise.
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].w, vecs[i].a, vecs[i].d,
                  vecs[i].ordy, vecs[i].fa);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].irdy, vecs[i].ov,
                          vecs[i].ow, vecs[i].oa, vecs[i].od, vecs[i].fh, vecs[i].fd);
        end

        // Steady streaming: one in, one out every cycle, data = cycle index.
        exp_q.delete();
        for (int k = 0; k < 100; k++) begin
            model_cycle("steady", 1'b1, 1'b1, 1'b0, 1'b1, AW'($urandom_range(0, 31)), DW'(k),
                        AW'($urandom_range(0, 31)));
            if (k >= 1) begin
                chk("steady_valid", 32'(out_valid), 32'd1);
                chk("steady_seq", out_regData, DW'(k - 1));
            end
        end

        // Random traffic with occasional flush; small address range to exercise forwarding.
        for (int k = 0; k < 600; k++) begin
            model_cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)),
                        AW'($urandom_range(0, 3)), $urandom, AW'($urandom_range(0, 3)));
        end

        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
